data_cache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller between the pipeline MEM stage and the 4-word-line data memory.
- Serves single-word loads and stores from the CPU.
- Stalls the pipeline with `busy` while a dirty victim is written back or a line is filled.
- Exposes hit and miss counters for performance reporting.

---
 rtl/data_cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache (4 lines x 4 words) between the
// MEM stage and a line-oriented data memory, with hit/miss performance counters.
module data_cache_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 busy,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0] mem_rdata1,
  input  logic [WORD_SIZE-1:0] mem_rdata2,
  input  logic [WORD_SIZE-1:0] mem_rdata3,
  input  logic [WORD_SIZE-1:0] mem_rdata4,
  output logic [WORD_SIZE-1:0] mem_wdata1,
  output logic [WORD_SIZE-1:0] mem_wdata2,
  output logic [WORD_SIZE-1:0] mem_wdata3,
  output logic [WORD_SIZE-1:0] mem_wdata4,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count,
  output logic [1:0]           state_dbg
);

  localparam int TAG_W = WORD_SIZE - 4;
  localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [4];
  logic [WORD_SIZE-1:0] data_q [4][4];
  logic [WORD_SIZE-1:0] wdata_q [4];
  logic [WORD_SIZE-1:0] addr_q, hit_q, miss_q;

  logic             req, hit, lat_done, do_hit, do_miss;
  logic [1:0]       idx, off;
  logic [TAG_W-1:0] req_tag;

  assign req      = req_read | req_write;
  assign idx      = req_addr[3:2];
  assign off      = req_addr[1:0];
  assign req_tag  = req_addr[WORD_SIZE-1:4];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign lat_done = (cnt_q == LAT_LAST);

  // Strobes derive from the state register so an async reset drops them at once.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    rdata      = '0;
    mem_readM  = 1'b0;
    mem_writeM = 1'b0;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            do_hit = 1'b1;
            if (req_read) rdata = data_q[idx][off];
          end else begin
            busy    = 1'b1;
            do_miss = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        busy       = 1'b1;
        mem_writeM = 1'b1;
        if (lat_done) state_d = S_FILL;
      end
      S_FILL: begin
        busy      = 1'b1;
        mem_readM = 1'b1;
        if (lat_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!Reset_N) begin
      busy  = 1'b0;
      rdata = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      addr_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      for (int i = 0; i < 4; i++) wdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (do_hit) begin
            hit_q <= hit_q + WORD_SIZE'(1);
            if (req_write) dirty_q[idx] <= 1'b1;
          end
          if (do_miss) begin
            miss_q <= miss_q + WORD_SIZE'(1);
            if (state_d == S_WRITEBACK) begin
              addr_q <= {tag_q[idx], idx, 2'b00};
              for (int i = 0; i < 4; i++) wdata_q[i] <= data_q[idx][i];
            end else begin
              addr_q <= {req_tag, idx, 2'b00};
            end
          end
        end
        S_WRITEBACK: begin
          if (lat_done) begin
            cnt_q        <= '0;
            dirty_q[idx] <= 1'b0;
            addr_q       <= {req_tag, idx, 2'b00};
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FILL: begin
          if (lat_done) begin
            cnt_q        <= '0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Line storage needs no reset: nothing is visible until valid is set by a fill.
  always_ff @(posedge Clk) begin
    if (state_q == S_IDLE && do_hit && req_write)
      data_q[idx][off] <= req_wdata;
    if (state_q == S_FILL && lat_done) begin
      tag_q[idx]     <= req_tag;
      data_q[idx][0] <= mem_rdata1;
      data_q[idx][1] <= mem_rdata2;
      data_q[idx][2] <= mem_rdata3;
      data_q[idx][3] <= mem_rdata4;
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata1  = wdata_q[0];
  assign mem_wdata2  = wdata_q[1];
  assign mem_wdata3  = wdata_q[2];
  assign mem_wdata4  = wdata_q[3];
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: miss/fill, write-back, hits, async reset and counter wrap.
module tb_data_cache_ctrl;

  logic        Clk, Reset_N;
  logic        req_read, req_write;
  logic [15:0] req_addr, req_wdata, rdata;
  logic        busy, mem_readM, mem_writeM;
  logic [15:0] mem_address;
  logic [15:0] mem_rdata1, mem_rdata2, mem_rdata3, mem_rdata4;
  logic [15:0] mem_wdata1, mem_wdata2, mem_wdata3, mem_wdata4;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int errors  = 0;

  // Results of the most recent request.
  int          busy_n, rd_n, wr_n, both_n;
  logic [15:0] rd_addr, wr_addr, rdata_done;
  logic [15:0] wd [4];

  data_cache_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(4)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .busy(busy),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
    .mem_rdata3(mem_rdata3), .mem_rdata4(mem_rdata4),
    .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
    .mem_wdata3(mem_wdata3), .mem_wdata4(mem_wdata4),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input logic [15:0] w0, w1, w2, w3);
    mem_rdata1 = w0; mem_rdata2 = w1; mem_rdata3 = w2; mem_rdata4 = w3;
  endtask

  // Drive a request and hold it until busy drops (bounded); leaves it asserted.
  task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data);
    bit done;
    busy_n = 0; rd_n = 0; wr_n = 0; both_n = 0; done = 0;
    rd_addr = 16'hxxxx; wr_addr = 16'hxxxx;
    for (int k = 0; k < 4; k++) wd[k] = 16'hxxxx;
    @(posedge Clk); #1;
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = data;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      if (mem_readM && mem_writeM) both_n++;
      if (mem_readM) begin
        if (rd_n == 0) rd_addr = mem_address;
        rd_n++;
      end
      if (mem_writeM) begin
        if (wr_n == 0) begin
          wr_addr = mem_address;
          wd[0] = mem_wdata1; wd[1] = mem_wdata2; wd[2] = mem_wdata3; wd[3] = mem_wdata4;
        end
        wr_n++;
      end
      if (busy) busy_n++;
      else begin
        done = 1;
        rdata_done = rdata;
      end
    end
    if (!done) check("busy_timeout", {15'd0, busy}, 16'd0);
    check("strobes_exclusive", 16'(both_n), 16'd0);
  endtask

  task automatic finish_req();
    @(posedge Clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    Reset_N = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    set_line(16'h0, 16'h0, 16'h0, 16'h0);
    #12;
    check("rst_busy",     {15'd0, busy}, 16'd0);
    check("rst_readM",    {15'd0, mem_readM}, 16'd0);
    check("rst_writeM",   {15'd0, mem_writeM}, 16'd0);
    check("rst_addr",     mem_address, 16'h0000);
    check("rst_wdata1",   mem_wdata1, 16'h0000);
    check("rst_rdata",    rdata, 16'h0000);
    check("rst_hits",     hit_count, 16'd0);
    check("rst_misses",   miss_count, 16'd0);
    check("rst_state",    {14'd0, state_dbg}, 16'd0);
    @(negedge Clk);
    Reset_N = 1'b1;

    // Clean miss on 0x0013: fill of 0x0010, then the held read hits word 3.
    set_line(16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3);
    run_req(1'b1, 1'b0, 16'h0013, 16'h0000);
    check("t1_busy_cycles", 16'(busy_n), 16'd5);
    check("t1_read_cycles", 16'(rd_n), 16'd4);
    check("t1_write_cycles", 16'(wr_n), 16'd0);
    check("t1_fill_addr", rd_addr, 16'h0010);
    check("t1_rdata", rdata_done, 16'hA3A3);
    finish_req();
    check("t1_hits", hit_count, 16'd1);
    check("t1_misses", miss_count, 16'd1);
    check("idle_rdata", rdata, 16'h0000);

    // Write hit, then read it back.
    run_req(1'b0, 1'b1, 16'h0011, 16'hBEEF);
    check("t2_wr_busy", 16'(busy_n), 16'd0);
    check("t2_wr_strobes", 16'(rd_n + wr_n), 16'd0);
    finish_req();
    run_req(1'b1, 1'b0, 16'h0011, 16'h0000);
    check("t2_rd_busy", 16'(busy_n), 16'd0);
    check("t2_rdata", rdata_done, 16'hBEEF);
    finish_req();
    check("t2_hits", hit_count, 16'd3);
    check("t2_misses", miss_count, 16'd1);

    // Conflict miss with a dirty victim: write-back then fill.
    set_line(16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3);
    run_req(1'b1, 1'b0, 16'h0111, 16'h0000);
    check("t3_busy_cycles", 16'(busy_n), 16'd9);
    check("t3_write_cycles", 16'(wr_n), 16'd4);
    check("t3_wb_addr", wr_addr, 16'h0010);
    check("t3_wdata1", wd[0], 16'hA0A0);
    check("t3_wdata2", wd[1], 16'hBEEF);
    check("t3_wdata3", wd[2], 16'hA2A2);
    check("t3_wdata4", wd[3], 16'hA3A3);
    check("t3_read_cycles", 16'(rd_n), 16'd4);
    check("t3_fill_addr", rd_addr, 16'h0110);
    check("t3_rdata", rdata_done, 16'hB1B1);
    finish_req();
    check("t3_hits", hit_count, 16'd4);
    check("t3_misses", miss_count, 16'd2);

    // Read and write together act as a write.
    run_req(1'b1, 1'b1, 16'h0112, 16'h1234);
    check("t4_busy", 16'(busy_n), 16'd0);
    finish_req();
    run_req(1'b1, 1'b0, 16'h0112, 16'h0000);
    check("t4_rdata", rdata_done, 16'h1234);
    finish_req();
    check("t4_hits", hit_count, 16'd6);

    // Reset during the second fill cycle of a clean miss on 0x0024.
    set_line(16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3);
    @(posedge Clk); #1;
    req_read = 1'b1; req_addr = 16'h0024;
    @(posedge Clk);
    @(posedge Clk); #2;
    check("t5_pre_readM", {15'd0, mem_readM}, 16'd1);
    check("t5_pre_state", {14'd0, state_dbg}, 16'd2);
    Reset_N = 1'b0;
    #1;
    check("t5_async_readM", {15'd0, mem_readM}, 16'd0);
    check("t5_async_busy", {15'd0, busy}, 16'd0);
    check("t5_async_hits", hit_count, 16'd0);
    check("t5_async_misses", miss_count, 16'd0);
    req_read = 1'b0;
    @(negedge Clk);
    Reset_N = 1'b1;
    run_req(1'b1, 1'b0, 16'h0013, 16'h0000);
    check("t5_old_line_miss", 16'(busy_n), 16'd5);
    check("t5_old_rdata", rdata_done, 16'hC3C3);
    finish_req();
    run_req(1'b1, 1'b0, 16'h0024, 16'h0000);
    check("t5_new_line_miss", 16'(busy_n), 16'd5);
    check("t5_new_rdata", rdata_done, 16'hC0C0);
    finish_req();
    check("t5_hits", hit_count, 16'd2);
    check("t5_misses", miss_count, 16'd2);

    // Hit counter wrap: hold a resident read for 65533 more hits, then one more.
    @(posedge Clk); #1;
    req_read = 1'b1; req_addr = 16'h0024;
    repeat (65533) @(posedge Clk);
    #1;
    req_read = 1'b0;
    @(negedge Clk);
    check("t6_hits_max", hit_count, 16'hFFFF);
    @(posedge Clk); #1;
    req_read = 1'b1;
    @(posedge Clk); #1;
    req_read = 1'b0;
    @(negedge Clk);
    check("t6_hits_wrap", hit_count, 16'h0000);
    check("t6_misses", miss_count, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
